score_controller: RTL and testbench

Game-score sequencer for the dinosaur game. It runs the IDLE/RUN/OVER game state machine and times score increments with a prescaler. It keeps a three-digit BCD running score and a best (high) score. It sits between the game-logic block, which supplies start, pause and collision, and the VGA seven-segment score renderer, which reads its digit outputs every pixel clock.

---
 rtl/score_controller_if.sv | 25 ++
 rtl/score_controller.sv | 103 ++++++++++
 tb/tb_score_controller.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/score_controller_if.sv
// Bus between the game-logic block and the score controller: control requests in,
// game state and BCD score/high-score digits out.
interface score_controller_if;
    logic       start;
    logic       pause;
    logic       collision;
    logic [1:0] state;
    logic [3:0] score_d0;
    logic [3:0] score_d1;
    logic [3:0] score_d2;
    logic [3:0] hi_d0;
    logic [3:0] hi_d1;
    logic [3:0] hi_d2;
    logic       score_tick;

    modport master (
        output start, pause, collision,
        input  state, score_d0, score_d1, score_d2, hi_d0, hi_d1, hi_d2, score_tick
    );

    modport slave (
        input  start, pause, collision,
        output state, score_d0, score_d1, score_d2, hi_d0, hi_d1, hi_d2, score_tick
    );
endinterface

// File: rtl/score_controller.sv
// Dinosaur-game score sequencer: IDLE/RUN/OVER state machine, prescaled BCD score
// counter saturating at 999, and a high score latched when a run ends.
module score_controller #(
    parameter int TICK_DIV = 10_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    score_controller_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        OVER = 2'b10
    } state_e;

    localparam logic [30:0] PRESC_LAST = 31'(TICK_DIV - 1);
    localparam logic [11:0] SCORE_MAX  = 12'h999;

    state_e      state_q, state_d;
    logic [30:0] presc_q, presc_d;
    logic [11:0] score_q, score_d;
    logic [11:0] hi_q, hi_d;
    logic        tick_q, tick_d;
    logic [11:0] score_inc;

    // Digit-wise BCD increment; only consumed when the score is below 999.
    always_comb begin
        score_inc = score_q;
        if (score_q[3:0] != 4'd9) begin
            score_inc[3:0] = score_q[3:0] + 4'd1;
        end else begin
            score_inc[3:0] = 4'd0;
            if (score_q[7:4] != 4'd9) begin
                score_inc[7:4] = score_q[7:4] + 4'd1;
            end else begin
                score_inc[7:4]  = 4'd0;
                score_inc[11:8] = score_q[11:8] + 4'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        score_d = score_q;
        hi_d    = hi_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d = RUN;
                    presc_d = '0;
                    score_d = '0;
                end
            end
            RUN: begin
                if (bus.collision) begin
                    state_d = OVER;
                    if (score_q > hi_q) begin
                        hi_d = score_q;
                    end
                end else if (!bus.pause) begin
                    if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        // Saturated score keeps the prescaler cycling but emits no tick.
                        if (score_q != SCORE_MAX) begin
                            score_d = score_inc;
                            tick_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 31'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            presc_q <= '0;
            score_q <= '0;
            hi_q    <= '0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            score_q <= score_d;
            hi_q    <= hi_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.score_d0   = score_q[3:0];
    assign bus.score_d1   = score_q[7:4];
    assign bus.score_d2   = score_q[11:8];
    assign bus.hi_d0      = hi_q[3:0];
    assign bus.hi_d1      = hi_q[7:4];
    assign bus.hi_d2      = hi_q[11:8];
    assign bus.score_tick = tick_q;
endmodule

// File: tb/tb_score_controller.sv
// Scoreboard bench for score_controller with TICK_DIV=4: an integer game model
// queues the expected outputs for every cycle and they are compared after each edge.
module tb_score_controller;
    localparam int TD = 4;

    logic clk;
    logic rst_n;
    score_controller_if bus ();

    score_controller #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [11:0] sc;
        logic [11:0] hi;
        logic        tk;
    } exp_t;

    exp_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    int m_state, m_score, m_hi, m_presc;
    bit m_tick;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [11:0] dut_score();
        return {bus.score_d2, bus.score_d1, bus.score_d0};
    endfunction

    function automatic logic [11:0] dut_hi();
        return {bus.hi_d2, bus.hi_d1, bus.hi_d0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want)
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_state = 0; m_score = 0; m_hi = 0; m_presc = 0; m_tick = 0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit c);
        m_tick = 0;
        if (m_state == 1) begin
            if (c) begin
                m_state = 2;
                if (m_score > m_hi) m_hi = m_score;
            end else if (!p) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    if (m_score < 999) begin
                        m_score++;
                        m_tick = 1;
                    end
                end else begin
                    m_presc++;
                end
            end
        end else if (s) begin
            m_state = 1; m_score = 0; m_presc = 0;
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.st = 2'(m_state);
        e.sc = to_bcd(m_score);
        e.hi = to_bcd(m_hi);
        e.tk = m_tick;
        exp_q.push_back(e);
    endtask

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("queue_size", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("state", 32'(bus.state), 32'(e.st));
        check("score", 32'(dut_score()), 32'(e.sc));
        check("hi", 32'(dut_hi()), 32'(e.hi));
        check("tick", 32'(bus.score_tick), 32'(e.tk));
    endtask

    task automatic step(input bit s, input bit p, input bit c);
        @(negedge clk);
        bus.start = s; bus.pause = p; bus.collision = c;
        model_step(s, p, c);
        push_expected();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic run_until_score(input int target, input int budget);
        int n = 0;
        while (m_score < target && n < budget) begin
            step(0, 0, 0);
            n++;
        end
        check("reach_score", 32'(dut_score()), 32'(to_bcd(target)));
    endtask

    task automatic collide_at_terminal();
        int n = 0;
        while (m_presc != TD - 1 && n < 2 * TD) begin
            step(0, 0, 0);
            n++;
        end
        step(0, 0, 1);
        $display("collision: state=%0d score=%03h hi=%03h", bus.state, dut_score(), dut_hi());
    endtask

    initial begin
        int n;
        int ticks;
        logic [11:0] held;
        bus.start = 0; bus.pause = 0; bus.collision = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        push_expected();
        compare_outputs();
        $display("reset: state=%0d score=%03h hi=%03h", bus.state, dut_score(), dut_hi());
        @(negedge clk);
        rst_n = 1'b1;

        // Game 1: basic timing, pause delay, collision at terminal count.
        step(1, 0, 0);
        $display("start: state=%0d score=%03h", bus.state, dut_score());
        repeat (2 * TD) step(0, 0, 0);
        check("first_two_ticks", 32'(dut_score()), 32'h002);
        n = 0;
        step(0, 0, 0); n++;
        repeat (3) begin step(0, 1, 0); n++; end
        while (bus.score_tick !== 1'b1 && n < 20) begin
            step(0, 0, 0); n++;
        end
        check("pause_gap", 32'(n), 32'(TD + 3));
        $display("pause: next tick after %0d cycles, score=%03h", n, dut_score());
        run_until_score(12, 200);
        held = dut_score();
        collide_at_terminal();
        check("g1_score_held", 32'(dut_score()), 32'(held));
        check("g1_hi", 32'(dut_hi()), 32'h012);

        // Game 2: lower score leaves the high score alone.
        step(1, 0, 0);
        run_until_score(5, 100);
        collide_at_terminal();
        check("g2_hi", 32'(dut_hi()), 32'h012);

        // Game 3: carries through 009 and 099, higher score replaces hi.
        step(1, 0, 0);
        run_until_score(123, 1000);
        collide_at_terminal();
        check("g3_hi", 32'(dut_hi()), 32'h123);
        repeat (3) step(0, 1, 1);

        // Game 4: start and collision together in OVER, then reset mid-run.
        step(1, 0, 1);
        $display("restart: state=%0d score=%03h hi=%03h", bus.state, dut_score(), dut_hi());
        check("restart_hi", 32'(dut_hi()), 32'h123);
        run_until_score(57, 500);
        check("pre_reset_hi", 32'(dut_hi()), 32'h123);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        push_expected();
        #1;
        compare_outputs();
        $display("async reset: state=%0d score=%03h hi=%03h", bus.state, dut_score(), dut_hi());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(0, 1, 1);
        check("idle_ignores", 32'(bus.state), 32'd0);

        // Game 5: saturate at 999, prescaler keeps wrapping without ticks.
        step(1, 0, 0);
        run_until_score(999, 5000);
        ticks = 0;
        repeat (10 * TD) begin
            step(0, 0, 0);
            if (bus.score_tick === 1'b1) ticks++;
        end
        check("sat_ticks", 32'(ticks), 32'd0);
        check("sat_score", 32'(dut_score()), 32'h999);
        collide_at_terminal();
        check("g5_hi", 32'(dut_hi()), 32'h999);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
